// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core-side dmem bus plus the TX FIFO drain handshake.
interface dmem_responder_if;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    modport master (
        output dmem_we, dmem_addr, dmem_wdata, out_ready,
        input  dmem_rdata, out_valid, out_data
    );
    modport slave (
        input  dmem_we, dmem_addr, dmem_wdata, out_ready,
        output dmem_rdata, out_valid, out_data
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO cycle counter, TX FIFO and status register for the core's dmem port.
// Optional DMEM_RAM_CLEAR_EN: reset also zeroes every RAM word.
module dmem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] cyc_q, cyc_d;
    logic ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0] sel;
    logic mmio, full, empty, push, pop, do_push, ram_we, cnt_we, ovf_clr;
    logic [31:0] status;
    logic unused_addr;

    assign mmio = bus.dmem_addr[31];
    assign idx = bus.dmem_addr[ADDR_WIDTH+1:2];
    assign sel = bus.dmem_addr[3:2];
    assign unused_addr = ^{bus.dmem_addr[30:ADDR_WIDTH+2], bus.dmem_addr[1:0]};
    assign full = cnt_q == CW'(FIFO_DEPTH);
    assign empty = cnt_q == '0;
    assign ram_we = bus.dmem_we & ~mmio;
    assign cnt_we = bus.dmem_we & mmio & (sel == 2'd0);
    assign push = bus.dmem_we & mmio & (sel == 2'd1);
    assign ovf_clr = bus.dmem_we & mmio & (sel == 2'd2) & bus.dmem_wdata[2];
    assign pop = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign status = {24'd0, 4'(cnt_q), 1'b0, ovf_q, empty, full};

    assign bus.out_valid = ~empty;
    assign bus.out_data = empty ? '0 : fifo_q[rd_q];
    assign bus.dmem_rdata = ~mmio ? mem_q[idx] : sel == 2'd0 ? cyc_q : sel == 2'd2 ? status : '0;

    always_comb begin
        wr_d = do_push ? wr_q + PW'(1) : wr_q;
        rd_d = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(pop);
        cyc_d = cnt_we ? bus.dmem_wdata : cyc_q + 32'd1;
        ovf_d = (push & full & ~pop) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            cyc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            cyc_q <= cyc_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) if (do_push) fifo_q[wr_q] <= bus.dmem_wdata;

`ifdef DMEM_RAM_CLEAR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
        end else if (ram_we) begin
            mem_q[idx] <= bus.dmem_wdata;
        end
    end
`else
    always_ff @(posedge clk) if (ram_we) mem_q[idx] <= bus.dmem_wdata;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with queued expectations checked by a negedge monitor.
module tb_dmem_responder;
    localparam logic [31:0] CNT = 32'h8000_0000;
    localparam logic [31:0] TX  = 32'h8000_0004;
    localparam logic [31:0] ST  = 32'h8000_0008;
    localparam logic [31:0] UNM = 32'h8000_000C;
`ifdef DMEM_RAM_CLEAR_EN
    localparam logic [31:0] RAM_AFTER_RST = 32'h0000_0000;
`else
    localparam logic [31:0] RAM_AFTER_RST = 32'hDEAD_BEEF;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rd_en = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rd[$];
    string nm_rd[$];
    logic [31:0] exp_fifo[$];

    dmem_responder_if bus();
    dmem_responder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // one bus cycle, from just after a rising edge to just after the next one
    task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic ck, input logic [31:0] e, input string n);
        bus.dmem_we = we;
        bus.dmem_addr = a;
        bus.dmem_wdata = d;
        if (ck) begin
            exp_rd.push_back(e);
            nm_rd.push_back(n);
        end
        rd_en = ck;
        @(posedge clk);
        #1;
        bus.dmem_we = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        op(1'b1, a, d, 1'b0, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        op(1'b0, a, 32'd0, 1'b1, e, n);
    endtask

    task automatic push(input logic [31:0] d, input logic kept);
        if (kept) exp_fifo.push_back(d);
        wr(TX, d);
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_underflow: got %h expected none", bus.dmem_rdata);
            end else chk(nm_rd.pop_front(), bus.dmem_rdata, exp_rd.pop_front());
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_fifo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_extra: got %h expected none", bus.out_data);
            end else chk("drain", bus.out_data, exp_fifo.pop_front());
        end
    end

    initial begin
        bus.dmem_we = 1'b0;
        bus.dmem_addr = 32'd0;
        bus.dmem_wdata = 32'd0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;
        rd(ST, 32'h02, "rst_status");
        rd(CNT, 32'd0, "rst_cnt");
        rd(UNM, 32'd0, "rst_unmapped");
        rst = 1'b1;
        // RAM write/read, aliasing and write-then-read ordering
        wr(32'h10, 32'h1234_5678);
        rd(32'h10, 32'h1234_5678, "ram_rd");
        rd(32'h113, 32'h1234_5678, "ram_alias");
        op(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "ram_old_same_cycle");
        rd(32'h10, 32'hDEAD_BEEF, "ram_new");
        // counter load and wrap
        wr(CNT, 32'hFFFF_FFFE);
        rd(CNT, 32'hFFFF_FFFE, "cnt_load");
        rd(CNT, 32'hFFFF_FFFF, "cnt_inc");
        rd(CNT, 32'h0000_0000, "cnt_wrap");
        rd(CNT, 32'h0000_0001, "cnt_after_wrap");
        // fill to overflow
        push(32'hA, 1'b1);
        push(32'hB, 1'b1);
        push(32'hC, 1'b1);
        push(32'hD, 1'b1);
        push(32'hE, 1'b0);
        rd(ST, 32'h45, "status_full_ovf");
        rd(TX, 32'h0, "txdata_rd");
        // push while full with a concurrent pop
        bus.out_ready = 1'b1;
        push(32'hF, 1'b1);
        bus.out_ready = 1'b0;
        rd(ST, 32'h45, "status_push_pop_full");
        bus.out_ready = 1'b1;
        repeat (4) op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "");
        bus.out_ready = 1'b0;
        rd(ST, 32'h06, "status_drained");
        chk("fifo_left", 32'(exp_fifo.size()), 32'd0);
        // overflow clear and unmapped access
        wr(ST, 32'h4);
        rd(ST, 32'h02, "status_ovf_clr");
        rd(UNM, 32'h0, "unmapped_rd");
        wr(UNM, 32'hFFFF_FFFF);
        rd(ST, 32'h02, "unmapped_wr");
        // reset in the middle of a drain
        push(32'h11, 1'b1);
        push(32'h22, 1'b1);
        push(32'h33, 1'b1);
        push(32'h44, 1'b1);
        rd(ST, 32'h41, "status_full");
        bus.out_ready = 1'b1;
        op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "");
        rst = 1'b0;
        bus.out_ready = 1'b0;
        bus.dmem_addr = ST;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_status", bus.dmem_rdata, 32'h02);
        exp_fifo.delete();
        @(posedge clk);
        #1;
        rd(32'h10, RAM_AFTER_RST, "ram_after_rst");
        rd(CNT, 32'd0, "cnt_in_rst");
        rst = 1'b1;
        rd(CNT, 32'd0, "cnt_release");
        rd(CNT, 32'd1, "cnt_release_inc");
        rd(ST, 32'h02, "status_release");
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
